// File: rtl/trace_mem_ctrl_if.sv
// Tracer/host-facing signal bundle of trace_mem_ctrl.
// The slave modport is the controller; the master modport is whatever drives it.
interface trace_mem_ctrl_if #(
    parameter int TRB_WIDTH = 32,
    parameter int ADDR_W    = 3
);
    logic                 EN_I;
    logic                 MODE_I;
    logic                 TRG_EVENT_I;
    logic [ADDR_W:0]      TRG_DELAY_I;
    logic                 TRG_DELAYED_O;
    logic                 STORE_I;
    logic [TRB_WIDTH-1:0] DATA_I;
    logic                 REQ_I;
    logic                 LOAD_O;
    logic [TRB_WIDTH-1:0] DATA_O;
    logic                 HOST_WR_I;
    logic [TRB_WIDTH-1:0] HOST_DATA_I;
    logic                 HOST_FULL_O;
    logic                 HOST_RD_I;
    logic [TRB_WIDTH-1:0] HOST_DATA_O;
    logic                 HOST_VALID_O;
    logic                 HOST_EMPTY_O;
    logic [ADDR_W:0]      COUNT_O;

    modport slave (
        input  EN_I, MODE_I, TRG_EVENT_I, TRG_DELAY_I, STORE_I, DATA_I, REQ_I,
               HOST_WR_I, HOST_DATA_I, HOST_RD_I,
        output TRG_DELAYED_O, LOAD_O, DATA_O, HOST_FULL_O, HOST_DATA_O,
               HOST_VALID_O, HOST_EMPTY_O, COUNT_O
    );

    modport master (
        output EN_I, MODE_I, TRG_EVENT_I, TRG_DELAY_I, STORE_I, DATA_I, REQ_I,
               HOST_WR_I, HOST_DATA_I, HOST_RD_I,
        input  TRG_DELAYED_O, LOAD_O, DATA_O, HOST_FULL_O, HOST_DATA_O,
               HOST_VALID_O, HOST_EMPTY_O, COUNT_O
    );
endinterface

// File: rtl/trace_mem_ctrl.sv
// Trace buffer / stream FIFO behind the tracer: circular capture with post-trigger
// freeze and host readback in trace mode, REQ/LOAD-served FIFO in stream mode.
module trace_mem_ctrl #(
    parameter int TRB_WIDTH = 32,
    parameter int TRB_DEPTH = 8,
    parameter int ADDR_W    = $clog2(TRB_DEPTH)
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    trace_mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {TRACE_FILL, TRACE_POST, FROZEN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(TRB_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [TRB_WIDTH-1:0] r_mem [TRB_DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]      r_count, r_post;
    logic                 r_pending, r_mode, r_delayed, r_full, r_empty;
    logic                 r_load, r_hvalid;
    logic [TRB_WIDTH-1:0] r_last, r_data, r_hdata;
    state_t               r_state;

    logic                 w_mode_chg, w_act, w_trace, w_strm;
    logic                 w_store, w_hwr, w_req, w_srv, w_hrd, w_we, w_freeze;
    logic [ADDR_W-1:0]    w_wr_nxt, w_rd_frz;
    logic [ADDR_W:0]      w_cnt_nxt, w_post_nxt;
    logic [TRB_WIDTH-1:0] w_wdata;
    state_t               w_state_nxt;

    // Once the buffer holds TRB_DEPTH words, further trace stores overwrite the oldest.
    function automatic logic [ADDR_W:0] f_sat_inc(input logic [ADDR_W:0] c);
        return (c == DEPTH_C) ? c : c + CNT_ONE;
    endfunction

    assign w_mode_chg = bus.EN_I && (bus.MODE_I != r_mode);
    assign w_act      = bus.EN_I && !w_mode_chg;
    assign w_trace    = w_act && !bus.MODE_I;
    assign w_strm     = w_act && bus.MODE_I;
    assign w_store    = w_trace && bus.STORE_I && (r_state != FROZEN);
    assign w_hwr      = w_strm && bus.HOST_WR_I && (r_count != DEPTH_C);
    assign w_req      = r_pending || bus.REQ_I;
    assign w_srv      = w_strm && w_req && (r_count != '0);
    assign w_hrd      = w_trace && bus.HOST_RD_I && (r_state == FROZEN) && (r_count != '0);
    assign w_we       = w_store || w_hwr;
    assign w_wdata    = bus.MODE_I ? bus.HOST_DATA_I : bus.DATA_I;
    assign w_wr_nxt   = w_we ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    // Oldest surviving word, computed from the post-edge pointer and count.
    assign w_rd_frz   = w_wr_nxt - w_cnt_nxt[ADDR_W-1:0];

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_store)
            w_cnt_nxt = f_sat_inc(r_count);
        else if (w_hwr && !w_srv)
            w_cnt_nxt = r_count + CNT_ONE;
        else if ((w_srv && !w_hwr) || w_hrd)
            w_cnt_nxt = r_count - CNT_ONE;

        w_state_nxt = r_state;
        w_post_nxt  = r_post;
        w_freeze    = 1'b0;
        if (w_trace) begin
            case (r_state)
                TRACE_FILL: begin
                    if (bus.TRG_EVENT_I) begin
                        if (bus.TRG_DELAY_I == '0) begin
                            w_freeze = 1'b1;
                        end else begin
                            w_state_nxt = TRACE_POST;
                            w_post_nxt  = bus.TRG_DELAY_I;
                        end
                    end
                end
                TRACE_POST: begin
                    if (w_store) begin
                        if (r_post == CNT_ONE) begin
                            w_freeze   = 1'b1;
                            w_post_nxt = '0;
                        end else begin
                            w_post_nxt = r_post - CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (w_freeze)
            w_state_nxt = FROZEN;
    end

    always_ff @(posedge CLK_I) begin
        if (w_we)
            r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_post    <= '0;
            r_pending <= 1'b0;
            r_mode    <= 1'b0;
            r_delayed <= 1'b0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_load    <= 1'b0;
            r_hvalid  <= 1'b0;
            r_last    <= '0;
            r_data    <= '0;
            r_hdata   <= '0;
            r_state   <= TRACE_FILL;
        end else begin
            r_load   <= 1'b0;
            r_hvalid <= 1'b0;
            if (bus.EN_I) begin
                r_mode <= bus.MODE_I;
                if (w_mode_chg) begin
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_count   <= '0;
                    r_post    <= '0;
                    r_pending <= 1'b0;
                    r_delayed <= 1'b0;
                    r_full    <= 1'b0;
                    r_empty   <= 1'b1;
                    r_last    <= '0;
                    r_state   <= TRACE_FILL;
                end else begin
                    r_wr_ptr <= w_wr_nxt;
                    r_count  <= w_cnt_nxt;
                    r_full   <= (w_cnt_nxt == DEPTH_C);
                    r_empty  <= (w_cnt_nxt == '0);
                    r_state  <= w_state_nxt;
                    r_post   <= w_post_nxt;
                    if (w_store)
                        r_last <= bus.DATA_I;
                    if (w_freeze) begin
                        r_rd_ptr  <= w_rd_frz;
                        r_delayed <= 1'b1;
                    end
                    if (w_hrd) begin
                        r_hdata  <= r_mem[r_rd_ptr];
                        r_hvalid <= 1'b1;
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    end
                    if (bus.MODE_I) begin
                        // A repeated REQ while one is outstanding merges into it.
                        r_pending <= w_req && !w_srv;
                        if (w_srv) begin
                            r_data   <= r_mem[r_rd_ptr];
                            r_load   <= 1'b1;
                            r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        end
                    end else if (bus.REQ_I) begin
                        r_data <= r_last;
                        r_load <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.TRG_DELAYED_O = r_delayed;
    assign bus.LOAD_O        = r_load;
    assign bus.DATA_O        = r_data;
    assign bus.HOST_FULL_O   = r_full;
    assign bus.HOST_DATA_O   = r_hdata;
    assign bus.HOST_VALID_O  = r_hvalid;
    assign bus.HOST_EMPTY_O  = r_empty;
    assign bus.COUNT_O       = r_count;
endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed self-checking bench for trace_mem_ctrl (TRB_DEPTH = 8, 32-bit words).
module tb_trace_mem_ctrl;
    localparam int W  = 32;
    localparam int AW = 3;

    logic CLK_I  = 1'b0;
    logic RST_NI = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    trace_mem_ctrl_if #(.TRB_WIDTH(W), .ADDR_W(AW)) bus ();

    trace_mem_ctrl #(.TRB_WIDTH(W), .TRB_DEPTH(8)) dut (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .bus    (bus.slave)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic idle();
        bus.STORE_I   = 1'b0;
        bus.REQ_I     = 1'b0;
        bus.HOST_WR_I = 1'b0;
        bus.HOST_RD_I = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.EN_I        = 1'b1;
        bus.MODE_I      = 1'b0;
        bus.TRG_EVENT_I = 1'b0;
        bus.TRG_DELAY_I = 4'd2;
        bus.DATA_I      = '0;
        bus.HOST_DATA_I = '0;
        idle();
        step();
        step();
        chk("rst_count", bus.COUNT_O, 0);
        chk("rst_empty", bus.HOST_EMPTY_O, 1);
        chk("rst_full", bus.HOST_FULL_O, 0);
        chk("rst_delayed", bus.TRG_DELAYED_O, 0);
        chk("rst_load", bus.LOAD_O, 0);
        chk("rst_data", bus.DATA_O, 0);
        RST_NI = 1'b1;
        step();

        // Trace fill: stores 1..10, trigger in an idle cycle, stores 11, 12 end the delay
        for (int i = 1; i <= 10; i++) begin
            bus.STORE_I = 1'b1; bus.DATA_I = i;
            step();
        end
        chk("fill_count_sat", bus.COUNT_O, 8);
        bus.STORE_I = 1'b0; bus.TRG_EVENT_I = 1'b1;
        step();
        bus.STORE_I = 1'b1; bus.DATA_I = 11;
        step();
        chk("post_not_frozen", bus.TRG_DELAYED_O, 0);
        bus.DATA_I = 12;
        step();
        chk("frozen_delayed", bus.TRG_DELAYED_O, 1);
        chk("frozen_count", bus.COUNT_O, 8);
        chk("frozen_full", bus.HOST_FULL_O, 1);
        bus.DATA_I = 13;
        step();
        chk("store13_ignored", bus.COUNT_O, 8);
        bus.STORE_I = 1'b0;
        bus.HOST_RD_I = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rb_valid%0d", k), bus.HOST_VALID_O, 1);
            chk($sformatf("rb_data%0d", k), bus.HOST_DATA_O, 5 + k);
        end
        step();
        chk("rb_empty_valid", bus.HOST_VALID_O, 0);
        chk("rb_empty", bus.HOST_EMPTY_O, 1);
        chk("rb_count0", bus.COUNT_O, 0);
        bus.HOST_RD_I = 1'b0; bus.REQ_I = 1'b1;
        step();
        chk("trace_req_load", bus.LOAD_O, 1);
        chk("trace_req_data", bus.DATA_O, 12);
        bus.REQ_I = 1'b0;
        step();
        chk("trace_load_pulse", bus.LOAD_O, 0);

        // Zero delay after a fresh reset
        RST_NI = 1'b0; bus.TRG_EVENT_I = 1'b0; bus.TRG_DELAY_I = 4'd0;
        #2;
        RST_NI = 1'b1;
        bus.REQ_I = 1'b1;
        step();
        chk("req_nothing_load", bus.LOAD_O, 1);
        chk("req_nothing_data", bus.DATA_O, 0);
        bus.REQ_I = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.STORE_I = 1'b1; bus.DATA_I = i;
            step();
        end
        bus.STORE_I = 1'b0; bus.TRG_EVENT_I = 1'b1;
        step();
        chk("zd_delayed", bus.TRG_DELAYED_O, 1);
        chk("zd_count", bus.COUNT_O, 3);
        bus.HOST_RD_I = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("zd_data%0d", k), bus.HOST_DATA_O, 1 + k);
        end
        bus.HOST_RD_I = 1'b0;

        // Mode change out of FROZEN clears status
        bus.TRG_EVENT_I = 1'b0; bus.MODE_I = 1'b1;
        step();
        chk("mc_delayed", bus.TRG_DELAYED_O, 0);
        chk("mc_count", bus.COUNT_O, 0);

        // Stream ordering
        for (int i = 0; i < 3; i++) begin
            bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'hA + i;
            step();
        end
        bus.HOST_WR_I = 1'b0;
        chk("st_count3", bus.COUNT_O, 3);
        for (int k = 0; k < 3; k++) begin
            bus.REQ_I = 1'b1;
            step();
            chk($sformatf("st_load%0d", k), bus.LOAD_O, 1);
            chk($sformatf("st_data%0d", k), bus.DATA_O, 32'hA + k);
            bus.REQ_I = 1'b0;
            step();
            chk($sformatf("st_pulse%0d", k), bus.LOAD_O, 0);
            step();
            step();
        end
        chk("st_count0", bus.COUNT_O, 0);

        // Pending request answered two cycles after the write
        bus.REQ_I = 1'b1;
        step();
        chk("pend_no_load", bus.LOAD_O, 0);
        bus.REQ_I = 1'b0;
        repeat (4) step();
        bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'h55;
        step();
        bus.HOST_WR_I = 1'b0;
        chk("pend_no_bypass", bus.LOAD_O, 0);
        step();
        chk("pend_load", bus.LOAD_O, 1);
        chk("pend_data", bus.DATA_O, 32'h55);
        chk("pend_count", bus.COUNT_O, 0);

        // Two REQs while empty merge into one request
        bus.REQ_I = 1'b1;
        step();
        step();
        bus.REQ_I = 1'b0;
        bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'h66;
        step();
        bus.HOST_DATA_I = 32'h77;
        step();
        chk("merge_load", bus.LOAD_O, 1);
        chk("merge_data", bus.DATA_O, 32'h66);
        bus.HOST_WR_I = 1'b0;
        step();
        chk("merge_single", bus.LOAD_O, 0);
        chk("merge_count", bus.COUNT_O, 1);
        bus.REQ_I = 1'b1;
        step();
        bus.REQ_I = 1'b0;
        chk("merge_drain", bus.DATA_O, 32'h77);

        // Full: write while full dropped, simultaneous read served
        for (int i = 0; i < 8; i++) begin
            bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'h10 + i;
            step();
        end
        chk("full_flag", bus.HOST_FULL_O, 1);
        chk("full_count", bus.COUNT_O, 8);
        bus.HOST_DATA_I = 32'hEE; bus.REQ_I = 1'b1;
        step();
        bus.HOST_WR_I = 1'b0;
        chk("full_load", bus.LOAD_O, 1);
        chk("full_data", bus.DATA_O, 32'h10);
        chk("full_count7", bus.COUNT_O, 7);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("full_drain%0d", k), bus.DATA_O, 32'h10 + k);
        end
        bus.REQ_I = 1'b0;
        step();
        chk("full_drained", bus.COUNT_O, 0);

        // Disabled cycles ignore strobes
        for (int i = 0; i < 3; i++) begin
            bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'h20 + i;
            step();
        end
        bus.EN_I = 1'b0; bus.REQ_I = 1'b1;
        step();
        chk("en0_count", bus.COUNT_O, 3);
        chk("en0_load", bus.LOAD_O, 0);
        bus.HOST_WR_I = 1'b0; bus.REQ_I = 1'b0; bus.EN_I = 1'b1;
        step();
        chk("en0_no_latch", bus.LOAD_O, 0);

        // Mode toggle with three words buffered
        bus.MODE_I = 1'b0;
        step();
        chk("mc3_count", bus.COUNT_O, 0);
        chk("mc3_delayed", bus.TRG_DELAYED_O, 0);
        chk("mc3_empty", bus.HOST_EMPTY_O, 1);

        // Asynchronous reset with no clock edge
        bus.MODE_I = 1'b1;
        step();
        bus.HOST_WR_I = 1'b1; bus.HOST_DATA_I = 32'h31;
        step();
        bus.HOST_WR_I = 1'b0; bus.REQ_I = 1'b1;
        step();
        bus.REQ_I = 1'b0;
        chk("pre_rst_load", bus.LOAD_O, 1);
        #2;
        RST_NI = 1'b0;
        #1;
        chk("arst_load", bus.LOAD_O, 0);
        chk("arst_data", bus.DATA_O, 0);
        chk("arst_count", bus.COUNT_O, 0);
        chk("arst_empty", bus.HOST_EMPTY_O, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
